// File: rtl/pll_reset_seq_if.sv
// pll_reset_seq_if
//   Groups the PLL lock input, the flag-clear strobe and the sequenced
//   reset/status outputs of the PLL reset sequencer.
//   Signals:
//     pll_lock       PLL LOCK flag, asynchronous to the sequencer clock
//     clr_lost       synchronous pulse clearing the lock_lost sticky flag
//     periph_resetn  active-low peripheral reset (registered)
//     cpu_resetn     active-low CPU reset (registered)
//     lock_lost      sticky flag: lock dropped after peripheral release
//     lost_cnt       saturating count of lock-loss events
//   Modports:
//     slave   the sequencer itself
//     master  the surrounding system (lock source, firmware, reset consumers)
interface pll_reset_seq_if #(
  parameter int LOST_W = 8
);
  logic              pll_lock;
  logic              clr_lost;
  logic              periph_resetn;
  logic              cpu_resetn;
  logic              lock_lost;
  logic [LOST_W-1:0] lost_cnt;

  modport slave (
    input  pll_lock,
    input  clr_lost,
    output periph_resetn,
    output cpu_resetn,
    output lock_lost,
    output lost_cnt
  );

  modport master (
    output pll_lock,
    output clr_lost,
    input  periph_resetn,
    input  cpu_resetn,
    input  lock_lost,
    input  lost_cnt
  );
endinterface

// File: rtl/pll_reset_seq.sv
// pll_reset_seq
//   Reset sequencer fed by the PLL lock flag. Lock is synchronised into the
//   free-running board clock domain, qualified as stable for STABLE_CYCLES
//   consecutive cycles, then peripheral reset is released, followed CPU_DELAY
//   cycles later by CPU reset. Any loss of lock after peripheral release
//   re-asserts both resets and is recorded (sticky flag + saturating counter).
//   A lock drop while still qualifying is treated as a glitch: qualification
//   restarts and nothing is recorded.
//   Ports:
//     clk_12M  free-running board clock, sole clock of this block
//     resetn   asynchronous active-low reset
//     bus      pll_reset_seq_if.slave (pll_lock, clr_lost in;
//              periph_resetn, cpu_resetn, lock_lost, lost_cnt out)
//   Consumers in PLL-derived domains must re-synchronise the deassertion of
//   periph_resetn/cpu_resetn locally.
module pll_reset_seq #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 256,
  parameter int CPU_DELAY     = 16,
  parameter int LOST_W        = 8
) (
  input  logic               clk_12M,
  input  logic               resetn,
  pll_reset_seq_if.slave     bus
);

  localparam int MAX_CYC = (STABLE_CYCLES > CPU_DELAY) ? STABLE_CYCLES : CPU_DELAY;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0]  STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CPU_LAST    = CNT_W'(CPU_DELAY - 1);
  localparam logic [LOST_W-1:0] LOST_MAX    = '1;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    STABLE,
    PERIPH,
    RUN
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  state_t                 state, next_state;
  logic [CNT_W-1:0]       cnt, next_cnt;
  logic                   loss_event;
  logic                   periph_d;
  logic                   cpu_d;

  // Lock synchroniser: pll_lock is asynchronous to clk_12M.
  always_ff @(posedge clk_12M or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_lock};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    loss_event = 1'b0;
    case (state)
      WAIT_LOCK: begin
        next_cnt = '0;
        if (lock_s) next_state = STABLE;
      end
      STABLE: begin
        if (!lock_s) begin
          next_state = WAIT_LOCK;
          next_cnt   = '0;
        end else if (cnt == STABLE_LAST) begin
          next_state = PERIPH;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + CNT_W'(1);
        end
      end
      PERIPH: begin
        if (!lock_s) begin
          next_state = WAIT_LOCK;
          next_cnt   = '0;
          loss_event = 1'b1;
        end else if (cnt == CPU_LAST) begin
          next_state = RUN;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          next_state = WAIT_LOCK;
          next_cnt   = '0;
          loss_event = 1'b1;
        end
      end
      default: begin
        next_state = WAIT_LOCK;
        next_cnt   = '0;
      end
    endcase
  end

  // Resets are decoded from the next state so they change on the same edge
  // as the state register; cpu release therefore always implies periph release.
  assign periph_d = (next_state == PERIPH) || (next_state == RUN);
  assign cpu_d    = (next_state == RUN);

  always_ff @(posedge clk_12M or negedge resetn) begin
    if (!resetn) begin
      state             <= WAIT_LOCK;
      cnt               <= '0;
      bus.periph_resetn <= 1'b0;
      bus.cpu_resetn    <= 1'b0;
      bus.lock_lost     <= 1'b0;
      bus.lost_cnt      <= '0;
    end else begin
      state             <= next_state;
      cnt               <= next_cnt;
      bus.periph_resetn <= periph_d;
      bus.cpu_resetn    <= cpu_d;
      // A loss on the same edge as clr_lost keeps the flag set.
      bus.lock_lost     <= loss_event | (bus.lock_lost & ~bus.clr_lost);
      if (loss_event && (bus.lost_cnt != LOST_MAX)) begin
        bus.lost_cnt <= bus.lost_cnt + LOST_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pll_reset_seq.sv
// tb_pll_reset_seq
//   Bench for pll_reset_seq. Two instances share clock, reset and stimulus:
//     A: default parameters (LOST_W=8)
//     B: SYNC_STAGES=2, STABLE_CYCLES=4, CPU_DELAY=3, LOST_W=2 (quick losses,
//        counter saturation)
//   The reference model tracks, per instance, the synchronised lock history
//   and the length of the current unbroken run of synced-lock-high edges:
//   peripheral reset is released once that run exceeds STABLE_CYCLES,
//   CPU reset once it exceeds STABLE_CYCLES+CPU_DELAY, and a loss event is a
//   synced-lock low after the run had already released peripheral reset.
module tb_pll_reset_seq;

  logic clk_12M;
  logic resetn;
  logic pll_lock;
  logic clr_lost;

  pll_reset_seq_if #(.LOST_W(8)) bus_a ();
  pll_reset_seq_if #(.LOST_W(2)) bus_b ();

  assign bus_a.pll_lock = pll_lock;
  assign bus_a.clr_lost = clr_lost;
  assign bus_b.pll_lock = pll_lock;
  assign bus_b.clr_lost = clr_lost;

  pll_reset_seq #(
    .SYNC_STAGES(2), .STABLE_CYCLES(256), .CPU_DELAY(16), .LOST_W(8)
  ) dut_a (
    .clk_12M(clk_12M), .resetn(resetn), .bus(bus_a.slave)
  );

  pll_reset_seq #(
    .SYNC_STAGES(2), .STABLE_CYCLES(4), .CPU_DELAY(3), .LOST_W(2)
  ) dut_b (
    .clk_12M(clk_12M), .resetn(resetn), .bus(bus_b.slave)
  );

  initial begin
    clk_12M = 1'b0;
    forever #5 clk_12M = ~clk_12M;
  end

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned ed       = 0;   // posedges since last reset release

  // Reference model state, index 0 = A, 1 = B
  int unsigned S  [2] = '{256, 4};
  int unsigned C  [2] = '{16, 3};
  int unsigned MX [2] = '{255, 3};
  int unsigned run_len [2];
  bit [1:0]    hist    [2];
  bit          flag    [2];
  int unsigned cntm    [2];

  typedef struct {
    int unsigned edge_n;
    bit          p;
    bit          c;
    bit          f;
    int unsigned cnt;
  } vec_t;

  vec_t pwrup [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t edge=%0d)", nm, act, exp, $time, ed);
  endtask

  task automatic chk_a(input string nm, input bit p, input bit c, input bit f, input int unsigned cnt);
    chk(nm, {bus_a.periph_resetn, bus_a.cpu_resetn, bus_a.lock_lost, bus_a.lost_cnt},
        {p, c, f, 8'(cnt)});
  endtask

  task automatic chk_b(input string nm, input bit p, input bit c, input bit f, input int unsigned cnt);
    chk(nm, {bus_b.periph_resetn, bus_b.cpu_resetn, bus_b.lock_lost, bus_b.lost_cnt},
        {p, c, f, 2'(cnt)});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      run_len[i] = 0;
      hist[i]    = '0;
      flag[i]    = 1'b0;
      cntm[i]    = 0;
    end
  endtask

  // Advance the model by one edge using the inputs the DUT is about to
  // sample, then step the clock and compare both instances.
  task automatic tick();
    bit ls;
    bit loss;
    for (int i = 0; i < 2; i++) begin
      if (!resetn) begin
        run_len[i] = 0;
        hist[i]    = '0;
        flag[i]    = 1'b0;
        cntm[i]    = 0;
      end else begin
        ls      = hist[i][1];
        hist[i] = {hist[i][0], pll_lock};
        loss    = 1'b0;
        if (ls) begin
          if (run_len[i] <= S[i] + C[i]) run_len[i]++;
        end else begin
          loss       = (run_len[i] > S[i]);
          run_len[i] = 0;
        end
        flag[i] = loss | (flag[i] & ~clr_lost);
        if (loss && cntm[i] < MX[i]) cntm[i]++;
      end
    end
    @(posedge clk_12M);
    #1;
    ed++;
    chk("model_a", {bus_a.periph_resetn, bus_a.cpu_resetn, bus_a.lock_lost, bus_a.lost_cnt},
        {run_len[0] > S[0], run_len[0] > S[0] + C[0], flag[0], 8'(cntm[0])});
    chk("model_b", {bus_b.periph_resetn, bus_b.cpu_resetn, bus_b.lock_lost, bus_b.lost_cnt},
        {run_len[1] > S[1], run_len[1] > S[1] + C[1], flag[1], 2'(cntm[1])});
  endtask

  task automatic run_to(input int unsigned n);
    while (ed < n) tick();
  endtask

  // Hold reset for two edges, release between edges; next posedge is edge 1.
  task automatic do_reset(input bit lock_val);
    resetn   = 1'b0;
    pll_lock = lock_val;
    clr_lost = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    ed     = 0;
  endtask

  task automatic apply_pwrup(input string tag);
    for (int k = 0; k < 6; k++) begin
      run_to(pwrup[k].edge_n);
      chk_a($sformatf("%s_e%0d", tag, pwrup[k].edge_n),
            pwrup[k].p, pwrup[k].c, pwrup[k].f, pwrup[k].cnt);
    end
  endtask

  initial begin
    pwrup[0] = '{edge_n: 1,   p: 0, c: 0, f: 0, cnt: 0};
    pwrup[1] = '{edge_n: 258, p: 0, c: 0, f: 0, cnt: 0};
    pwrup[2] = '{edge_n: 259, p: 1, c: 0, f: 0, cnt: 0};
    pwrup[3] = '{edge_n: 274, p: 1, c: 0, f: 0, cnt: 0};
    pwrup[4] = '{edge_n: 275, p: 1, c: 1, f: 0, cnt: 0};
    pwrup[5] = '{edge_n: 300, p: 1, c: 1, f: 0, cnt: 0};

    resetn   = 1'b0;
    pll_lock = 1'b0;
    clr_lost = 1'b0;
    model_reset();
    #2;
    chk_a("reset_a", 0, 0, 0, 0);
    chk_b("reset_b", 0, 0, 0, 0);

    // Clean power-up, then loss in RUN and full requalification
    do_reset(1'b1);
    apply_pwrup("pwrup");
    pll_lock = 1'b0;
    run_to(302);
    chk_a("run_loss_e302", 1, 1, 0, 0);
    run_to(303);
    chk_a("run_loss_e303", 0, 0, 1, 1);
    pll_lock = 1'b1;
    run_to(561);
    chk_a("relock_e561", 0, 0, 1, 1);
    run_to(562);
    chk_a("relock_e562", 1, 0, 1, 1);
    run_to(577);
    chk_a("relock_e577", 1, 0, 1, 1);
    run_to(578);
    chk_a("relock_e578", 1, 1, 1, 1);

    // Asynchronous reset mid-RUN, between clock edges
    #2;
    resetn = 1'b0;
    #1;
    chk_a("async_rst", 0, 0, 0, 0);
    chk_b("async_rst_b", 0, 0, 0, 0);
    model_reset();
    tick();
    resetn = 1'b1;
    ed     = 0;
    apply_pwrup("restart");

    // Glitch while qualifying: 3 low samples at edges 100..102
    do_reset(1'b1);
    run_to(99);
    pll_lock = 1'b0;
    run_to(102);
    pll_lock = 1'b1;
    run_to(259);
    chk_a("glitch_e259", 0, 0, 0, 0);
    run_to(360);
    chk_a("glitch_e360", 0, 0, 0, 0);
    run_to(361);
    chk_a("glitch_e361", 1, 0, 0, 0);

    // Loss while in PERIPH
    do_reset(1'b1);
    run_to(265);
    chk_a("periph_e265", 1, 0, 0, 0);
    pll_lock = 1'b0;
    run_to(267);
    chk_a("periph_e267", 1, 0, 0, 0);
    run_to(268);
    chk_a("periph_e268", 0, 0, 1, 1);
    run_to(300);
    chk_a("periph_e300", 0, 0, 1, 1);

    // Instance B: clr_lost on the loss edge, then saturation
    do_reset(1'b1);
    run_to(12);
    chk_b("b_run", 1, 1, 0, 0);
    pll_lock = 1'b0;
    run_to(14);
    clr_lost = 1'b1;
    tick();
    clr_lost = 1'b0;
    chk_b("b_clr_vs_loss", 0, 0, 1, 1);
    clr_lost = 1'b1;
    tick();
    clr_lost = 1'b0;
    chk_b("b_clr", 0, 0, 0, 1);
    for (int ev = 2; ev <= 5; ev++) begin
      pll_lock = 1'b1;
      for (int k = 0; k < 12; k++) tick();
      pll_lock = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      chk_b($sformatf("b_sat_ev%0d", ev), 0, 0, 1, (ev > 3) ? 3 : ev);
    end

    // Randomised lock traffic, flag clears and occasional resets
    do_reset(1'b0);
    for (int seg = 0; seg < 60; seg++) begin
      int unsigned hi_len;
      int unsigned lo_len;
      hi_len = ($urandom_range(0, 3) == 0) ? $urandom_range(250, 300) : $urandom_range(1, 15);
      lo_len = $urandom_range(1, 6);
      pll_lock = 1'b1;
      for (int unsigned k = 0; k < hi_len; k++) begin
        clr_lost = ($urandom_range(0, 7) == 0);
        tick();
      end
      pll_lock = 1'b0;
      for (int unsigned k = 0; k < lo_len; k++) begin
        clr_lost = ($urandom_range(0, 3) == 0);
        tick();
      end
      if ($urandom_range(0, 19) == 0) begin
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
      end
    end
    clr_lost = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
